// File: rtl/register32_8_pkg.sv
// Shared definitions for the 8 x 32-bit register bank burst reader.
package register32_8_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int LEN_W    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // A request length of 0, or anything beyond the bank size, reads the whole bank.
  function automatic logic [LEN_W-1:0] effective_len(input logic [LEN_W-1:0] len);
    if ((len == '0) || (len > LEN_W'(NUM_REGS))) begin
      return LEN_W'(NUM_REGS);
    end
    return len;
  endfunction

endpackage

// File: rtl/register32_8_reader_if.sv
// Command and output-stream signals of the burst reader.
interface register32_8_reader_if
  import register32_8_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                  rd_req;
  logic                  rd_ready;
  logic [ADDR_W-1:0]     rd_addr;
  logic [LEN_W-1:0]      rd_len;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  d_valid;
  logic                  d_ready;
  logic [ADDR_W-1:0]     d_addr;
  logic                  d_last;
  logic                  busy;

  // Requester / stream consumer side.
  modport master (
    output rd_req, rd_addr, rd_len, d_ready,
    input  rd_ready, d_out, d_valid, d_addr, d_last, busy
  );

  // Reader side.
  modport slave (
    input  rd_req, rd_addr, rd_len, d_ready,
    output rd_ready, d_out, d_valid, d_addr, d_last, busy
  );
endinterface

// File: rtl/mux8_32.sv
// Combinational 8:1 word select over the register bank outputs.
module mux8_32
  import register32_8_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_W-1:0]     sel,
  input  logic [DATA_WIDTH-1:0] d0,
  input  logic [DATA_WIDTH-1:0] d1,
  input  logic [DATA_WIDTH-1:0] d2,
  input  logic [DATA_WIDTH-1:0] d3,
  input  logic [DATA_WIDTH-1:0] d4,
  input  logic [DATA_WIDTH-1:0] d5,
  input  logic [DATA_WIDTH-1:0] d6,
  input  logic [DATA_WIDTH-1:0] d7,
  output logic [DATA_WIDTH-1:0] y
);

  // Pick the register addressed by sel.
  always_comb begin
    y = d0;
    case (sel)
      3'd0: y = d0;
      3'd1: y = d1;
      3'd2: y = d2;
      3'd3: y = d3;
      3'd4: y = d4;
      3'd5: y = d5;
      3'd6: y = d6;
      3'd7: y = d7;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/register32_8_reader.sv
// Burst read sequencer: takes (start address, length) and streams bank words
// one per accepted beat, wrapping 7 -> 0, with full downstream backpressure.
module register32_8_reader
  import register32_8_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] d_in0,
  input  logic [DATA_WIDTH-1:0] d_in1,
  input  logic [DATA_WIDTH-1:0] d_in2,
  input  logic [DATA_WIDTH-1:0] d_in3,
  input  logic [DATA_WIDTH-1:0] d_in4,
  input  logic [DATA_WIDTH-1:0] d_in5,
  input  logic [DATA_WIDTH-1:0] d_in6,
  input  logic [DATA_WIDTH-1:0] d_in7,
  register32_8_reader_if.slave  bus
);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_W-1:0]     r_ptr;
  logic [LEN_W-1:0]      r_remaining;
  logic [DATA_WIDTH-1:0] r_d_out;
  logic [ADDR_W-1:0]     r_d_addr;
  logic                  r_d_valid;
  logic                  r_d_last;

  logic                  w_rd_ready;
  logic                  w_busy;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_final;
  logic [LEN_W-1:0]      w_eff_len;
  logic [DATA_WIDTH-1:0] w_cmd_word;
  logic [DATA_WIDTH-1:0] w_ptr_word;

  assign w_eff_len = effective_len(bus.rd_len);
  assign w_accept  = bus.rd_req && w_rd_ready;
  assign w_beat    = r_d_valid && bus.d_ready;
  assign w_final   = w_beat && (r_remaining == '0);

  // First word of a burst comes from the command address.
  mux8_32 #(.DATA_WIDTH(DATA_WIDTH)) u_mux_cmd (
    .sel (bus.rd_addr),
    .d0  (d_in0), .d1 (d_in1), .d2 (d_in2), .d3 (d_in3),
    .d4  (d_in4), .d5 (d_in5), .d6 (d_in6), .d7 (d_in7),
    .y   (w_cmd_word)
  );

  // Subsequent words come from the running pointer.
  mux8_32 #(.DATA_WIDTH(DATA_WIDTH)) u_mux_ptr (
    .sel (r_ptr),
    .d0  (d_in0), .d1 (d_in1), .d2 (d_in2), .d3 (d_in3),
    .d4  (d_in4), .d5 (d_in5), .d6 (d_in6), .d7 (d_in7),
    .y   (w_ptr_word)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-decoded outputs; rd_ready depends only on the state.
  always_comb begin
    w_state_next = r_state;
    w_rd_ready   = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_rd_ready = 1'b1;
        if (bus.rd_req) begin
          w_state_next = BURST;
        end
      end
      BURST: begin
        w_busy = 1'b1;
        if (w_final) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Pointer, counter and output word: load on accept, advance on each beat, hold on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_d_out     <= '0;
      r_d_addr    <= '0;
      r_d_valid   <= 1'b0;
      r_d_last    <= 1'b0;
    end else if (w_accept) begin
      r_d_out     <= w_cmd_word;
      r_d_addr    <= bus.rd_addr;
      r_d_valid   <= 1'b1;
      r_ptr       <= bus.rd_addr + ADDR_W'(1);
      r_remaining <= w_eff_len - LEN_W'(1);
      r_d_last    <= (w_eff_len == LEN_W'(1));
    end else if (w_beat) begin
      if (r_remaining == '0) begin
        r_d_valid <= 1'b0;
        r_d_last  <= 1'b0;
      end else begin
        r_d_out     <= w_ptr_word;
        r_d_addr    <= r_ptr;
        r_ptr       <= r_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
        r_d_last    <= (r_remaining == LEN_W'(1));
      end
    end
  end

  assign bus.rd_ready = w_rd_ready;
  assign bus.busy     = w_busy;
  assign bus.d_out    = r_d_out;
  assign bus.d_addr   = r_d_addr;
  assign bus.d_valid  = r_d_valid;
  assign bus.d_last   = r_d_last;

endmodule

// File: tb/tb_register32_8_reader.sv
// Scoreboard bench for register32_8_reader: directed commands push expected
// words; a negedge monitor compares every presented word and pops on beats.
module tb_register32_8_reader;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  addr;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] bank [8];
  beat_t       exp_q [$];
  int          n_checks;
  int          n_errors;

  register32_8_reader_if #(.DATA_WIDTH(32)) bus ();

  register32_8_reader #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d_in0   (bank[0]),
    .d_in1   (bank[1]),
    .d_in2   (bank[2]),
    .d_in3   (bank[3]),
    .d_in4   (bank[4]),
    .d_in5   (bank[5]),
    .d_in6   (bank[6]),
    .d_in7   (bank[7]),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must match the queue head; pop on a beat.
  always @(negedge clk) begin
    if (reset_n && bus.d_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: actual=0x%08h addr=%0d required=no word", bus.d_out, bus.d_addr);
      end else begin
        n_checks++;
        if ((bus.d_out !== exp_q[0].data) || (bus.d_addr !== exp_q[0].addr) ||
            (bus.d_last !== exp_q[0].last)) begin
          n_errors++;
          $display("FAIL stream_word: actual=0x%08h/%0d/%0b required=0x%08h/%0d/%0b",
                   bus.d_out, bus.d_addr, bus.d_last,
                   exp_q[0].data, exp_q[0].addr, exp_q[0].last);
        end
        if (bus.d_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] a, input logic l);
    beat_t b;
    b.data = d;
    b.addr = a;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic reset_bank();
    for (int k = 0; k < 8; k++) bank[k] = 32'h1000_0000 + 32'(k);
  endtask

  // Present a command for one cycle; it must be accepted and the first word appear.
  task automatic issue(input logic [2:0] a, input logic [3:0] l);
    chk("rd_ready_before_cmd", {31'd0, bus.rd_ready}, 32'd1);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    bus.rd_len  = l;
    tick();
    bus.rd_req  = 1'b0;
    bus.rd_addr = 3'd0;
    bus.rd_len  = 4'd0;
    chk("first_word_valid", {31'd0, bus.d_valid}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rd_ready"}, {31'd0, bus.rd_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_d_valid"}, {31'd0, bus.d_valid}, 32'd0);
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Full-rate burst of n words starting at st (expected words hand-tabulated
  // from the bank pattern 0x1000_000k).
  task automatic burst_full(input string tag, input logic [2:0] st, input logic [3:0] l, input int n);
    logic [2:0] a;
    bus.d_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = st + 3'(i);
      push(32'h1000_0000 + 32'(a), a, (i == n - 1));
    end
    issue(st, l);
    for (int i = 0; i < n; i++) tick();
    check_idle(tag);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset_n     = 1'b0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = 3'd0;
    bus.rd_len  = 4'd0;
    bus.d_ready = 1'b0;
    reset_bank();

    // Reset state, then idle with no request.
    tick();
    tick();
    chk("rst_d_out", bus.d_out, 32'd0);
    chk("rst_d_addr", {29'd0, bus.d_addr}, 32'd0);
    chk("rst_d_valid", {31'd0, bus.d_valid}, 32'd0);
    chk("rst_d_last", {31'd0, bus.d_last}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
    reset_n = 1'b1;
    bus.d_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("idle_no_req_valid", {31'd0, bus.d_valid}, 32'd0);

    // Basic burst, wrap with len=0, clamp len=9, single word at top address.
    burst_full("basic", 3'd2, 4'd3, 3);
    burst_full("wrap_len0", 3'd6, 4'd0, 8);
    burst_full("clamp_len9", 3'd3, 4'd9, 8);
    burst_full("len1_addr7", 3'd7, 4'd1, 1);

    // Backpressure; bank writes during stalls.
    push(32'h1000_0000, 3'd0, 1'b0);
    push(32'h1000_0001, 3'd1, 1'b0);
    push(32'h1000_0002, 3'd2, 1'b0);
    push(32'hCAFE_0003, 3'd3, 1'b1);
    bus.d_ready = 1'b1;
    issue(3'd0, 4'd4);
    bus.d_ready = 1'b0;
    bank[0] = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("stall_hold_word0", bus.d_out, 32'h1000_0000);
    bus.d_ready = 1'b1;
    tick();
    tick();
    bus.d_ready = 1'b0;
    bank[3] = 32'hCAFE_0003;
    tick();
    chk("stall_hold_busy", {31'd0, bus.busy}, 32'd1);
    bus.d_ready = 1'b1;
    tick();
    tick();
    check_idle("backpressure");
    reset_bank();

    // Ignored request during a burst, then abort by reset after the second beat.
    bus.d_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(32'h1000_0001 + 32'(i), 3'(1 + i), (i == 4));
    issue(3'd1, 4'd5);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 3'd5;
    bus.rd_len  = 4'd2;
    chk("busy_rd_ready_low", {31'd0, bus.rd_ready}, 32'd0);
    chk("busy_high", {31'd0, bus.busy}, 32'd1);
    tick();
    bus.rd_req  = 1'b0;
    bus.rd_addr = 3'd0;
    bus.rd_len  = 4'd0;
    chk("ignored_req_addr", {29'd0, bus.d_addr}, 32'd2);
    tick();
    chk("abort_words_sent", 32'(exp_q.size()), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("abort_d_valid", {31'd0, bus.d_valid}, 32'd0);
    chk("abort_d_out", bus.d_out, 32'd0);
    chk("abort_d_last", {31'd0, bus.d_last}, 32'd0);
    chk("abort_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_abort_idle", {31'd0, bus.d_valid}, 32'd0);
    burst_full("after_abort", 3'd4, 4'd2, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
